// File: rtl/membus_arb4.sv
// Four-master arbiter in front of a single shared memory port. One master at a time
// is granted; its request, address and write data go to memory and the responses come back.
module membus_arb4 #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned RR      = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     m_rq_cyc,
    input  logic [3:0]     m_rd_rq,
    input  logic [3:0]     m_wr_rq,
    input  logic [3:0]     m_wr_rs,
    input  logic [59:0]    m_ma,
    input  logic [15:0]    m_sel,
    input  logic [143:0]   m_mb_in,
    output logic [3:0]     m_addr_ack,
    output logic [3:0]     m_rd_rs,
    output logic [143:0]   m_mb_out,
    output logic [3:0]     m_nxm,
    output logic           s_rq_cyc,
    output logic           s_rd_rq,
    output logic           s_wr_rq,
    output logic           s_wr_rs,
    output logic [14:0]    s_ma,
    output logic [3:0]     s_sel,
    output logic [35:0]    s_mb_out,
    input  logic           s_addr_ack,
    input  logic           s_rd_rs,
    input  logic [35:0]    s_mb_in,
    output logic [3:0]     gnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        RDWAIT = 3'd2,
        WRWAIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [9:0] TMO = 10'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  g_q, g_d;
    logic [1:0]  last_q, last_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [3:0]  nxm_q, nxm_d;

    logic [1:0]  idx_v;
    logic [1:0]  pick_s;
    logic        found_s;
    logic [14:0] ma_g_s;
    logic [3:0]  sel_g_s;
    logic [35:0] wd_g_s;

    assign ma_g_s  = m_ma[15*g_q +: 15];
    assign sel_g_s = m_sel[4*g_q +: 4];
    assign wd_g_s  = m_mb_in[36*g_q +: 36];

    // Arbitration: search starts just after the last completed grant in round-robin mode.
    always_comb begin
        pick_s  = 2'd0;
        found_s = 1'b0;
        idx_v   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (RR != 0) begin
                idx_v = last_q + 2'd1 + k[1:0];
            end else begin
                idx_v = k[1:0];
            end
            if (!found_s && m_rq_cyc[idx_v]) begin
                found_s = 1'b1;
                pick_s  = idx_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        g_d     = g_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        nxm_d   = 4'b0000;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    gnt_d   = 4'b0001 << pick_s;
                    g_d     = pick_s;
                    rd_d    = m_rd_rq[pick_s];
                    wr_d    = m_wr_rq[pick_s];
                    cnt_d   = 10'd0;
                    state_d = ADDR;
                end else begin
                    gnt_d   = 4'b0000;
                end
            end
            ADDR: begin
                // An ack in the same cycle as expiry wins over the timeout.
                if (!m_rq_cyc[g_q]) begin
                    state_d = DONE;
                end else if (s_addr_ack) begin
                    if (rd_q) begin
                        state_d = RDWAIT;
                    end else if (wr_q) begin
                        state_d = WRWAIT;
                    end else begin
                        state_d = DONE;
                    end
                end else if (cnt_q == TMO) begin
                    nxm_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 10'd1;
                end
            end
            RDWAIT: begin
                if (!m_rq_cyc[g_q]) begin
                    state_d = DONE;
                end else if (s_rd_rs) begin
                    state_d = wr_q ? WRWAIT : DONE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            WRWAIT: begin
                if (!m_rq_cyc[g_q] || m_wr_rs[g_q]) begin
                    state_d = DONE;
                end else begin
                    state_d = WRWAIT;
                end
            end
            DONE: begin
                if (!m_rq_cyc[g_q] && !s_addr_ack) begin
                    last_d  = g_q;
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            g_q     <= 2'd0;
            last_q  <= 2'd3;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= 10'd0;
            nxm_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            g_q     <= g_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            nxm_q   <= nxm_d;
        end
    end

    assign gnt   = gnt_q;
    assign m_nxm = nxm_q;

    // Routing between the granted master slice and the memory port.
    always_comb begin
        s_rq_cyc   = 1'b0;
        s_rd_rq    = 1'b0;
        s_wr_rq    = 1'b0;
        s_wr_rs    = 1'b0;
        s_ma       = 15'd0;
        s_sel      = 4'd0;
        s_mb_out   = 36'd0;
        m_mb_out   = 144'd0;
        m_addr_ack = gnt_q & {4{s_addr_ack}};
        m_rd_rs    = gnt_q & {4{s_rd_rs}};
        case (state_q)
            ADDR: begin
                s_rq_cyc = 1'b1;
                s_rd_rq  = rd_q;
                s_wr_rq  = wr_q;
                s_ma     = ma_g_s;
                s_sel    = sel_g_s;
            end
            RDWAIT: begin
                s_rq_cyc = 1'b1;
                s_ma     = ma_g_s;
                s_sel    = sel_g_s;
                if (s_rd_rs) begin
                    m_mb_out[36*g_q +: 36] = s_mb_in;
                end else begin
                    m_mb_out = 144'd0;
                end
            end
            WRWAIT: begin
                s_rq_cyc = 1'b1;
                s_ma     = ma_g_s;
                s_sel    = sel_g_s;
                s_mb_out = wd_g_s;
                s_wr_rs  = m_wr_rs[g_q];
            end
            default: begin
                s_rq_cyc = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_membus_arb4.sv
// Self-checking bench for membus_arb4: a table of single-master transactions plus
// hand-written sequences for arbitration order, timeout and asynchronous reset.
module tb_membus_arb4;
    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [3:0]     m_rq_cyc = 4'd0, m_rd_rq = 4'd0, m_wr_rq = 4'd0, m_wr_rs = 4'd0;
    logic [59:0]    m_ma = 60'd0;
    logic [15:0]    m_sel = 16'd0;
    logic [143:0]   m_mb_in = 144'd0;
    logic           s_addr_ack = 1'b0, s_rd_rs = 1'b0;
    logic [35:0]    s_mb_in = 36'd0;

    logic [3:0]     m_addr_ack, m_rd_rs, m_nxm, gnt;
    logic [143:0]   m_mb_out;
    logic           s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs;
    logic [14:0]    s_ma;
    logic [3:0]     s_sel;
    logic [35:0]    s_mb_out;

    logic [3:0]     fp_addr_ack, fp_rd_rs, fp_nxm, fp_gnt;
    logic [143:0]   fp_mb_out;
    logic           fp_rq_cyc, fp_rd_rq, fp_wr_rq, fp_wr_rs;
    logic [14:0]    fp_ma;
    logic [3:0]     fp_sel;
    logic [35:0]    fp_mb_o;

    membus_arb4 #(.TIMEOUT(15), .RR(1)) dut (
        .clk(clk), .reset(reset), .m_rq_cyc(m_rq_cyc), .m_rd_rq(m_rd_rq), .m_wr_rq(m_wr_rq),
        .m_wr_rs(m_wr_rs), .m_ma(m_ma), .m_sel(m_sel), .m_mb_in(m_mb_in),
        .m_addr_ack(m_addr_ack), .m_rd_rs(m_rd_rs), .m_mb_out(m_mb_out), .m_nxm(m_nxm),
        .s_rq_cyc(s_rq_cyc), .s_rd_rq(s_rd_rq), .s_wr_rq(s_wr_rq), .s_wr_rs(s_wr_rs),
        .s_ma(s_ma), .s_sel(s_sel), .s_mb_out(s_mb_out),
        .s_addr_ack(s_addr_ack), .s_rd_rs(s_rd_rs), .s_mb_in(s_mb_in), .gnt(gnt)
    );

    membus_arb4 #(.TIMEOUT(15), .RR(0)) dut_fp (
        .clk(clk), .reset(reset), .m_rq_cyc(m_rq_cyc), .m_rd_rq(m_rd_rq), .m_wr_rq(m_wr_rq),
        .m_wr_rs(m_wr_rs), .m_ma(m_ma), .m_sel(m_sel), .m_mb_in(m_mb_in),
        .m_addr_ack(fp_addr_ack), .m_rd_rs(fp_rd_rs), .m_mb_out(fp_mb_out), .m_nxm(fp_nxm),
        .s_rq_cyc(fp_rq_cyc), .s_rd_rq(fp_rd_rq), .s_wr_rq(fp_wr_rq), .s_wr_rs(fp_wr_rs),
        .s_ma(fp_ma), .s_sel(fp_sel), .s_mb_out(fp_mb_o),
        .s_addr_ack(s_addr_ack), .s_rd_rs(s_rd_rs), .s_mb_in(s_mb_in), .gnt(fp_gnt)
    );

    always #5 clk = ~clk;

    logic [218:0] all_o;
    assign all_o = {m_addr_ack, m_rd_rs, m_mb_out, m_nxm, s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs,
                    s_ma, s_sel, s_mb_out, gnt};

    typedef struct {
        int unsigned    m;
        logic           rd;
        logic           wr;
        logic [14:0]    ma;
        logic [3:0]     sel;
        logic [35:0]    wd;
        logic [35:0]    rdat;
        logic [3:0]     exp_gnt;
        logic [143:0]   exp_mb;
    } vec_t;

    vec_t        tv[4];
    logic [3:0]  sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_rq_cyc = 4'd0; m_rd_rq = 4'd0; m_wr_rq = 4'd0; m_wr_rs = 4'd0;
        s_addr_ack = 1'b0; s_rd_rs = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    function automatic logic [3:0] gsel(input bit fp);
        return fp ? fp_gnt : gnt;
    endfunction

    function automatic int unsigned oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // Repeated arbitration with all four masters requesting; each releases for one cycle in DONE.
    task automatic run_all4(input bit fp);
        logic [3:0] got;
        int unsigned g;
        int w;
        m_rd_rq = 4'd0; m_wr_rq = 4'd0;
        m_rq_cyc = 4'hF;
        for (int n = 0; n < 5; n++) begin
            w = 0;
            while (gsel(fp) == 4'd0 && w < 5) begin
                step();
                w++;
            end
            got = gsel(fp);
            chk(fp ? "fixed_order" : "rr_order", got, sb_q.pop_front());
            g = oh_idx(got);
            s_addr_ack = 1'b1;
            step();
            s_addr_ack = 1'b0;
            m_rq_cyc[g] = 1'b0;
            step();
            m_rq_cyc = 4'hF;
        end
        m_rq_cyc = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic acked;
        vec_t v;

        tv[0] = '{1, 1'b1, 1'b0, 15'o01234, 4'b0011, 36'o0, 36'o123456701234, 4'b0010,
                  {36'h0, 36'h0, 36'o123456701234, 36'h0}};
        tv[1] = '{3, 1'b1, 1'b1, 15'o52525, 4'b1000, 36'o765432107654, 36'o400000000001, 4'b1000,
                  {36'o400000000001, 36'h0, 36'h0, 36'h0}};
        tv[2] = '{0, 1'b0, 1'b1, 15'o00017, 4'b0101, 36'o111122223333, 36'o0, 4'b0001, 144'h0};
        tv[3] = '{2, 1'b0, 1'b0, 15'o70000, 4'b1110, 36'o0, 36'o0, 4'b0100, 144'h0};

        // Reset state
        step();
        chk("reset_outputs", all_o, 219'd0);
        do_reset();
        chk("after_reset_gnt", gnt, 4'b0000);

        // Masters 0 and 2 together after reset
        sb_q.push_back(4'b0001);
        sb_q.push_back(4'b0100);
        m_rq_cyc = 4'b0101;
        step();
        chk("pair_first_gnt", gnt, sb_q.pop_front());
        s_addr_ack = 1'b1;
        #1;
        chk("pair_ack_route", m_addr_ack, 4'b0001);
        step();
        s_addr_ack = 1'b0;
        m_rq_cyc = 4'b0100;
        step();
        chk("pair_idle_gap", gnt, 4'b0000);
        step();
        chk("pair_second_gnt", gnt, sb_q.pop_front());
        s_addr_ack = 1'b1;
        step();
        s_addr_ack = 1'b0;
        m_rq_cyc = 4'b0000;
        step();
        step();

        // Table of single-master transactions
        m_ma = '1; m_sel = '1; m_mb_in = '1;
        for (int i = 0; i < 4; i++) begin
            v = tv[i];
            m_ma[15*v.m +: 15] = v.ma;
            m_sel[4*v.m +: 4] = v.sel;
            m_mb_in[36*v.m +: 36] = v.wd;
            m_rd_rq = v.rd ? (4'b0001 << v.m) : ~(4'b0001 << v.m);
            m_wr_rq = v.wr ? (4'b0001 << v.m) : ~(4'b0001 << v.m);
            m_rq_cyc = 4'b0001 << v.m;
            step();
            chk("tv_gnt", gnt, v.exp_gnt);
            chk("tv_addr_phase", {s_rq_cyc, s_rd_rq, s_wr_rq, s_ma, s_sel},
                {1'b1, v.rd, v.wr, v.ma, v.sel});
            chk("tv_no_ack_yet", m_addr_ack, 4'b0000);
            s_addr_ack = 1'b1;
            #1;
            chk("tv_ack_route", m_addr_ack, v.exp_gnt);
            step();
            s_addr_ack = 1'b0;
            if (v.rd) begin
                s_mb_in = v.rdat;
                #1;
                chk("tv_rd_idle_data", {m_rd_rs, m_mb_out, s_rq_cyc}, {4'b0000, 144'h0, 1'b1});
                s_rd_rs = 1'b1;
                #1;
                chk("tv_rd_rs", m_rd_rs, v.exp_gnt);
                chk("tv_rd_data", m_mb_out, v.exp_mb);
                step();
                s_rd_rs = 1'b0;
            end
            if (v.wr) begin
                m_wr_rs = ~(4'b0001 << v.m);
                #1;
                chk("tv_wr_data", {s_mb_out, s_wr_rs, s_rq_cyc}, {v.wd, 1'b0, 1'b1});
                m_wr_rs = 4'hF;
                #1;
                chk("tv_wr_rs", s_wr_rs, 1'b1);
                step();
                m_wr_rs = 4'd0;
            end
            chk("tv_done", {s_rq_cyc, s_ma, s_sel, s_mb_out, s_wr_rs, gnt},
                {1'b0, 15'd0, 4'd0, 36'd0, 1'b0, v.exp_gnt});
            m_rq_cyc = 4'd0;
            step();
            chk("tv_idle", gnt, 4'b0000);
            step();
        end
        m_ma = '0; m_sel = '0; m_mb_in = '0;

        // Address timeout
        m_rq_cyc = 4'b0010; m_rd_rq = 4'd0; m_wr_rq = 4'd0;
        step();
        chk("tmo_gnt", gnt, 4'b0010);
        n = 0;
        acked = 1'b0;
        while (m_nxm == 4'd0 && n < 40) begin
            if (m_addr_ack != 4'd0) acked = 1'b1;
            step();
            n++;
        end
        chk("tmo_latency", n, 16);
        chk("tmo_nxm", {m_nxm, s_rq_cyc, acked}, {4'b0010, 1'b0, 1'b0});
        step();
        chk("tmo_pulse_len", m_nxm, 4'b0000);
        m_rq_cyc = 4'd0;
        step();
        chk("tmo_idle", gnt, 4'b0000);

        // Ack coinciding with expiry wins
        m_rq_cyc = 4'b0010; m_rd_rq = 4'b0010;
        step();
        repeat (15) step();
        s_addr_ack = 1'b1;
        step();
        s_addr_ack = 1'b0;
        chk("tmo_ack_wins", {m_nxm, s_rq_cyc}, {4'b0000, 1'b1});
        m_rq_cyc = 4'd0;
        step();
        chk("drop_rdwait", s_rq_cyc, 1'b0);
        step();
        chk("drop_idle", gnt, 4'b0000);

        // Continuous requests: round-robin then fixed priority
        do_reset();
        sb_q.push_back(4'b0001); sb_q.push_back(4'b0010); sb_q.push_back(4'b0100);
        sb_q.push_back(4'b1000); sb_q.push_back(4'b0001);
        run_all4(1'b0);
        do_reset();
        repeat (5) sb_q.push_back(4'b0001);
        run_all4(1'b1);

        // Asynchronous reset during RDWAIT
        do_reset();
        m_rq_cyc = 4'b0100; m_rd_rq = 4'b0100;
        step();
        s_addr_ack = 1'b1;
        step();
        s_addr_ack = 1'b0;
        chk("rst_rdwait", s_rq_cyc, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", all_o, 219'd0);
        #1;
        reset = 1'b1;
        step();
        chk("rst_regrant", {gnt, s_rq_cyc}, {4'b0100, 1'b1});
        m_rq_cyc = 4'd0;
        step();
        chk("rst_drop_addr", {gnt, s_rq_cyc}, {4'b0100, 1'b0});
        step();
        chk("rst_final_idle", gnt, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/membus_arb4.md
MEMBUS_ARB4 -- requirements
Module: membus_arb4

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: cycles to wait in ADDR for s_addr_ack before aborting; 10-bit counter.
REQ-002 SHALL have parameter RR, default 1: 1 = round-robin priority, 0 = fixed priority with master 0 highest.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- m_rq_cyc  in  4  per-master cycle request.
- m_rd_rq  in  4  per-master read request.
- m_wr_rq  in  4  per-master write request.
- m_wr_rs  in  4  per-master write restart (write data valid).
- m_ma  in  60  per-master address; master i in bits [15i+14:15i].
- m_sel  in  16  per-master memory select; master i in bits [4i+3:4i].
- m_mb_in  in  144  per-master write data; master i in bits [36i+35:36i].
- m_addr_ack  out  4  routed address acknowledge.
- m_rd_rs  out  4  routed read restart.
- m_mb_out  out  144  routed read data; zero for non-granted masters.
- m_nxm  out  4  one-cycle pulse: timeout for that master.
- s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs  out  1 each  shared memory port requests.
- s_ma  out  15; s_sel  out  4; s_mb_out  out  36  address/select/write data to memory.
- s_addr_ack, s_rd_rs  in  1 each; s_mb_in  in  36  memory responses.
- gnt  out  4  one-hot current grant; 0 when idle.

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, RDWAIT, WRWAIT, DONE.
REQ-005 IDLE: if any m_rq_cyc bit is set, SHALL register a one-hot gnt on the next edge and enter ADDR; if none is set, SHALL stay in IDLE with gnt=0.
REQ-006 RR=1: the search SHALL start at master (last+1) mod 4, where last is the most recently completed grant (reset value 3, so master 0 wins first). RR=0: lowest index SHALL win.
REQ-007 On grant, SHALL latch rd=m_rd_rq[g], wr=m_wr_rq[g], and clear the timeout counter.
REQ-008 In ADDR, SHALL drive s_rq_cyc=1, s_rd_rq=rd, s_wr_rq=wr, s_ma=m_ma[g], s_sel=m_sel[g] combinationally from the granted slice.
REQ-009 While granted, SHALL route m_addr_ack[g]=s_addr_ack and m_rd_rs[g]=s_rd_rs combinationally (zero latency); all other masters SHALL receive 0.
REQ-010 In RDWAIT, m_mb_out[g] SHALL equal s_mb_in whenever s_rd_rs=1 and SHALL be 0 otherwise; other slices SHALL be 0 always.
REQ-011 ADDR on s_addr_ack: rd=1 -> RDWAIT; rd=0, wr=1 -> WRWAIT; neither -> DONE.
REQ-012 RDWAIT on s_rd_rs: wr=1 (read-modify-write) -> WRWAIT; else -> DONE.
REQ-013 In WRWAIT, s_mb_out SHALL equal m_mb_in[g] and s_wr_rs SHALL equal m_wr_rs[g]; on m_wr_rs[g]=1, SHALL go to DONE.
REQ-014 s_rq_cyc SHALL stay high from ADDR through WRWAIT and SHALL be 0 in IDLE and DONE.
REQ-015 DONE: when m_rq_cyc[g]=0 and s_addr_ack=0, SHALL update last=g, clear gnt, and go to IDLE; otherwise SHALL hold.
REQ-016 In IDLE and DONE, s_ma, s_sel and s_mb_out SHALL be 0; in IDLE and DONE, s_wr_rs SHALL be 0.
REQ-017 In ADDR, the counter SHALL increment each cycle; if it reaches TIMEOUT with no s_addr_ack, SHALL pulse m_nxm[g] for one cycle and go to DONE.
REQ-018 If m_rq_cyc[g] drops in ADDR, RDWAIT or WRWAIT, SHALL go to DONE with no response routed.
REQ-019 If s_addr_ack and timeout expiry coincide, s_addr_ack SHALL take precedence and m_nxm SHALL NOT pulse.
REQ-020 Requests arriving while not in IDLE SHALL be held off with no ack; they SHALL be arbitrated on the next IDLE evaluation.
REQ-021 Minimum spacing between grants SHALL be one IDLE cycle.

Reset
REQ-022 reset low SHALL asynchronously force: state=IDLE, gnt=0, last=3, rd=wr=0, counter=0, and every output to 0.
REQ-023 reset asserted mid-transaction SHALL abandon the transaction; after release, arbitration SHALL restart from IDLE.

Verification
REQ-024 Masters 0 and 2 request together, RR=1, after reset -> master 0 granted; after its release, master 2 granted; gnt = 0001, then 0000, then 0100.
REQ-025 Master 1 reads address 0o01234; memory acks, then gives rd_rs with data 0o123456701234 -> m_rd_rs[1]=1, m_mb_out[1]=0o123456701234; other slices 0.
REQ-026 Master 3 does read-modify-write -> RDWAIT then WRWAIT; s_mb_out=m_mb_in[3] during m_wr_rs[3]; then DONE; then IDLE after rq_cyc drops.
REQ-027 No s_addr_ack, TIMEOUT=15 -> m_nxm[g] pulses 16 cycles after entry to ADDR; s_rq_cyc drops; no m_addr_ack.
REQ-028 All four masters request continuously, RR=1 -> grant order 0,1,2,3,0; RR=0 -> master 0 repeatedly.
REQ-029 reset low during RDWAIT -> all outputs 0 immediately; after release, a pending request is granted from IDLE.
